// File: rtl/neur_pkg.sv
// Shared types and per-precision constants for the neural-unit SIMD multiply responder.
package neur_pkg;

    typedef enum logic [1:0] {
        NEUR_W16  = 2'b00,
        NEUR_W8   = 2'b01,
        NEUR_W4   = 2'b10,
        NEUR_RSVD = 2'b11
    } neur_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } neur_state_e;

    localparam logic [2:0] LPC_W16 = 3'd1;
    localparam logic [2:0] LPC_W8  = 3'd2;
    localparam logic [2:0] LPC_W4  = 3'd4;

    localparam int ELEM_W16 = 16;
    localparam int ELEM_W8  = 8;
    localparam int ELEM_W4  = 4;

    function automatic logic [2:0] lanes_per_cycle(input neur_mode_e mode);
        case (mode)
            NEUR_W8: lanes_per_cycle = LPC_W8;
            NEUR_W4: lanes_per_cycle = LPC_W4;
            default: lanes_per_cycle = LPC_W16;
        endcase
    endfunction

    function automatic int elem_width(input neur_mode_e mode);
        case (mode)
            NEUR_W8: elem_width = ELEM_W8;
            NEUR_W4: elem_width = ELEM_W4;
            default: elem_width = ELEM_W16;
        endcase
    endfunction

    function automatic logic [2:0] compute_cycles(input neur_mode_e mode);
        case (mode)
            NEUR_W8: compute_cycles = 3'd2;
            NEUR_W4: compute_cycles = 3'd1;
            default: compute_cycles = 3'd4;
        endcase
    endfunction

    // Reserved encoding behaves as full 16-bit precision.
    function automatic neur_mode_e norm_mode(input neur_mode_e mode);
        norm_mode = (mode == NEUR_RSVD) ? NEUR_W16 : mode;
    endfunction

endpackage

// File: rtl/neur_lane_mul.sv
// Combinational slice of the dot product: signed sum of the lane products
// selected for one compute step (1, 2 or 4 lanes starting at lane_idx).
module neur_lane_mul
    import neur_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 16,
    parameter int RES_W     = 32
) (
    input  logic [NUM_LANES-1:0][LANE_W-1:0] oper_a,
    input  logic [NUM_LANES-1:0][LANE_W-1:0] oper_b,
    input  neur_mode_e                       mode,
    input  logic [1:0]                       lane_idx,
    output logic [RES_W-1:0]                 lane_sum
);

    int                                ext_shift;
    logic [2:0]                        lane_lo;
    logic [2:0]                        lane_hi;
    logic [NUM_LANES-1:0]              lane_sel;
    logic [NUM_LANES-1:0][RES_W-1:0]   lane_prod;

    // Sign extension from the element width is a left-align then arithmetic right shift.
    assign ext_shift = LANE_W - elem_width(mode);
    assign lane_lo   = {1'b0, lane_idx};
    assign lane_hi   = lane_lo + lanes_per_cycle(mode);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [2:0] LANE_ID = 3'(gi);
            logic signed [LANE_W-1:0]   a_ext;
            logic signed [LANE_W-1:0]   b_ext;
            logic signed [2*LANE_W-1:0] prod_full;

            always_comb begin
                a_ext = $signed(oper_a[gi] << ext_shift) >>> ext_shift;
                b_ext = $signed(oper_b[gi] << ext_shift) >>> ext_shift;
            end

            assign prod_full     = a_ext * b_ext;
            assign lane_prod[gi] = RES_W'(prod_full);
            assign lane_sel[gi]  = (LANE_ID >= lane_lo) && (LANE_ID < lane_hi);
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_sel[i]) begin
                lane_sum = lane_sum + lane_prod[i];
            end
        end
    end

endmodule

// File: rtl/neur_simd_mul_unit.sv
// Neural-unit multiply responder: accepts four packed lane pairs and returns their
// signed dot product, iterating by precision and stalling while the core owns the array.
module neur_simd_mul_unit
    import neur_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 16,
    parameter int RES_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              neur_mul_en_i,
    input  logic [1:0]        neur_mode_i,
    input  logic [LANE_W-1:0] neur_oper_a0_i,
    input  logic [LANE_W-1:0] neur_oper_a1_i,
    input  logic [LANE_W-1:0] neur_oper_a2_i,
    input  logic [LANE_W-1:0] neur_oper_a3_i,
    input  logic [LANE_W-1:0] neur_oper_b0_i,
    input  logic [LANE_W-1:0] neur_oper_b1_i,
    input  logic [LANE_W-1:0] neur_oper_b2_i,
    input  logic [LANE_W-1:0] neur_oper_b3_i,
    input  logic              cpu_mult_busy_i,
    output logic              neur_mul_ready_o,
    output logic              neur_mul_valid_o,
    output logic [RES_W-1:0]  neur_mul_res_o,
    output logic              neur_mul_overrun_o
);

    localparam logic [2:0] LANES_TOTAL = 3'(NUM_LANES);

    neur_state_e                      state_reg, state_next;
    neur_mode_e                       mode_reg, mode_next;
    logic [NUM_LANES-1:0][LANE_W-1:0] a_reg, a_next;
    logic [NUM_LANES-1:0][LANE_W-1:0] b_reg, b_next;
    logic [NUM_LANES-1:0][LANE_W-1:0] a_in, b_in;
    logic [RES_W-1:0]                 acc_reg, acc_next;
    logic [RES_W-1:0]                 res_reg, res_next;
    logic [2:0]                       cnt_reg, cnt_next;
    logic [2:0]                       lpc;
    logic [2:0]                       cnt_adv;
    logic [RES_W-1:0]                 lane_sum;
    logic [RES_W-1:0]                 acc_sum;
    logic                             ready;
    logic                             accept;

    assign a_in = {neur_oper_a3_i, neur_oper_a2_i, neur_oper_a1_i, neur_oper_a0_i};
    assign b_in = {neur_oper_b3_i, neur_oper_b2_i, neur_oper_b1_i, neur_oper_b0_i};

    assign ready   = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept  = neur_mul_en_i && ready;
    assign lpc     = lanes_per_cycle(mode_reg);
    assign cnt_adv = cnt_reg + lpc;
    assign acc_sum = acc_reg + lane_sum;

    neur_lane_mul #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W),
        .RES_W     (RES_W)
    ) u_lane_mul (
        .oper_a   (a_reg),
        .oper_b   (b_reg),
        .mode     (mode_reg),
        .lane_idx (cnt_reg[1:0]),
        .lane_sum (lane_sum)
    );

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;

        case (state_reg)
            ST_IDLE:    state_next = neur_mul_en_i ? ST_COMPUTE : ST_IDLE;
            ST_DONE:    state_next = neur_mul_en_i ? ST_COMPUTE : ST_IDLE;
            ST_COMPUTE: begin
                // The shared multiplier array belongs to the core while busy.
                if (!cpu_mult_busy_i) begin
                    acc_next = acc_sum;
                    cnt_next = cnt_adv;
                    if (cnt_adv >= LANES_TOTAL) begin
                        res_next   = acc_sum;
                        state_next = ST_DONE;
                    end
                end
            end
            default:    state_next = ST_IDLE;
        endcase

        if (accept) begin
            mode_next = norm_mode(neur_mode_e'(neur_mode_i));
            a_next    = a_in;
            b_next    = b_in;
            acc_next  = '0;
            cnt_next  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            mode_reg  <= NEUR_W16;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
        end
    end

    assign neur_mul_ready_o   = ready;
    assign neur_mul_valid_o   = (state_reg == ST_DONE);
    assign neur_mul_res_o     = res_reg;
    assign neur_mul_overrun_o = neur_mul_en_i && (state_reg == ST_COMPUTE);

endmodule

// File: tb/tb_neur_simd_mul_unit.sv
// Directed bench for neur_simd_mul_unit: vector table plus stall/overrun,
// back-to-back and mid-operation reset sequences.
module tb_neur_simd_mul_unit;

    typedef struct {
        string            name;
        logic [1:0]       mode;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [31:0]      res;
        int               lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] a_lane [4];
    logic [15:0] b_lane [4];
    logic        busy;
    logic        ready;
    logic        valid;
    logic [31:0] res;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [6];
    vec_t v_b2b;

    neur_simd_mul_unit dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .neur_mul_en_i      (en),
        .neur_mode_i        (mode),
        .neur_oper_a0_i     (a_lane[0]),
        .neur_oper_a1_i     (a_lane[1]),
        .neur_oper_a2_i     (a_lane[2]),
        .neur_oper_a3_i     (a_lane[3]),
        .neur_oper_b0_i     (b_lane[0]),
        .neur_oper_b1_i     (b_lane[1]),
        .neur_oper_b2_i     (b_lane[2]),
        .neur_oper_b3_i     (b_lane[3]),
        .cpu_mult_busy_i    (busy),
        .neur_mul_ready_o   (ready),
        .neur_mul_valid_o   (valid),
        .neur_mul_res_o     (res),
        .neur_mul_overrun_o (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic [1:0] m,
                                input logic [15:0] a0, a1, a2, a3,
                                input logic [15:0] b0, b1, b2, b3,
                                input logic [31:0] r, input int lat);
        vec_t v;
        v.name = name;
        v.mode = m;
        v.a    = {a3, a2, a1, a0};
        v.b    = {b3, b2, b1, b0};
        v.res  = r;
        v.lat  = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mode = v.mode;
        for (int i = 0; i < 4; i++) begin
            a_lane[i] = v.a[i];
            b_lane[i] = v.b[i];
        end
    endtask

    // Called just after a rising edge; the en cycle counts as cycle 0.
    task automatic run_op(input vec_t v);
        int cyc;
        drive(v);
        en = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        cyc = 1;
        while (!valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
        chk({v.name, " res"}, res, v.res);
        chk({v.name, " ready_in_done"}, {31'd0, ready}, 32'd1);
        $display("op %s mode=%0d res=%h latency=%0d", v.name, v.mode, res, cyc);
        @(posedge clk); #1;
        chk({v.name, " valid_one_cycle"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int nv, no, vcyc, ocyc;
        logic [31:0] vres;

        vecs[0] = mk("w16_mixed", 2'b00, 16'd1000, 16'hFFFE, 16'd3, 16'h8000,
                     16'd2000, 16'd5, 16'hFFF9, 16'h8000, 32'h401E8461, 5);
        vecs[1] = mk("w8_junk_hi", 2'b01, 16'hAB7F, 16'h1280, 16'hFF01, 16'h00FF,
                     16'h5502, 16'hEE02, 16'h3305, 16'h7703, 32'h00000000, 3);
        vecs[2] = mk("w4_junk_hi", 2'b10, 16'h1237, 16'hFFF8, 16'hABC1, 16'h5A5F,
                     16'h0008, 16'h7777, 16'h1230, 16'hEEE1, 32'hFFFFFF8F, 2);
        vecs[3] = mk("w16_wrap", 2'b00, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                     16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h00000000, 5);
        vecs[4] = mk("w8_min_sq", 2'b01, 16'h0080, 16'h0080, 16'h0080, 16'h0080,
                     16'h0080, 16'h0080, 16'h0080, 16'h0080, 32'h00010000, 3);
        vecs[5] = mk("rsvd_as_w16", 2'b11, 16'd1000, 16'hFFFE, 16'd3, 16'h8000,
                     16'd2000, 16'd5, 16'hFFF9, 16'h8000, 32'h401E8461, 5);
        v_b2b   = mk("w4_second", 2'b10, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                     16'h0002, 16'h0002, 16'h0002, 16'h0002, 32'h00000008, 2);

        rst_n = 1'b0;
        en    = 1'b0;
        busy  = 1'b0;
        mode  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            a_lane[i] = '0;
            b_lane[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset res", res, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // Stall for cycles 2..4 and a dropped request in cycle 3.
        drive(vecs[0]);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        nv = 0; no = 0; vcyc = 0; ocyc = 0; vres = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            busy = (cyc >= 2 && cyc <= 4);
            en   = (cyc == 3);
            if (cyc == 3) drive(vecs[2]);
            #1;
            if (overrun) begin no++; ocyc = cyc; end
            if (valid) begin nv++; vcyc = cyc; vres = res; end
            @(posedge clk); #1;
        end
        busy = 1'b0;
        en   = 1'b0;
        chk("stall valid_cycle", 32'(vcyc), 32'd8);
        chk("stall valid_count", 32'(nv), 32'd1);
        chk("stall res", vres, 32'h401E8461);
        chk("overrun count", 32'(no), 32'd1);
        chk("overrun cycle", 32'(ocyc), 32'd3);
        $display("op stall_overrun res=%h valid_cycle=%0d overrun_cycle=%0d", vres, vcyc, ocyc);

        // Back-to-back: second request issued in the DONE cycle of the first.
        drive(vecs[2]);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        #1 chk("b2b c1 valid", {31'd0, valid}, 32'd0);
        @(posedge clk); #1;
        chk("b2b c2 valid", {31'd0, valid}, 32'd1);
        chk("b2b c2 ready", {31'd0, ready}, 32'd1);
        chk("b2b c2 res", res, 32'hFFFFFF8F);
        drive(v_b2b);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk("b2b c3 valid", {31'd0, valid}, 32'd0);
        chk("b2b c3 ready", {31'd0, ready}, 32'd0);
        chk("b2b c3 res_held", res, 32'hFFFFFF8F);
        @(posedge clk); #1;
        chk("b2b c4 valid", {31'd0, valid}, 32'd1);
        chk("b2b c4 res", res, 32'h00000008);
        $display("op back_to_back res=%h", res);
        @(posedge clk); #1;
        chk("b2b c5 valid", {31'd0, valid}, 32'd0);

        // Asynchronous reset in the second COMPUTE cycle of a W16 op.
        drive(vecs[0]);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst valid", {31'd0, valid}, 32'd0);
        chk("rst res", res, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (valid) nv++;
            @(posedge clk); #1;
        end
        chk("rst no_valid", 32'(nv), 32'd0);
        chk("rst res_after", res, 32'd0);
        $display("op reset_mid_op valid_pulses=%0d res=%h", nv, res);
        run_op(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
